// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t : sequencer state (IDLE, RUN, DRAIN)
//   fetch_entry_t : one prefetch FIFO entry {pc, inst}
//   FETCH_DEPTH   : prefetch FIFO depth
// The entry struct is sized by FETCH_ADDR_W / FETCH_INST_W. The top-level
// INS_ADDRESS / INS_W parameters default to these and must agree with them.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_ADDR_W = 9;
  localparam int FETCH_INST_W = 32;
  localparam int FETCH_DEPTH  = 2;
  localparam int FETCH_CNT_W  = 2;

  // FIFO occupancy value meaning "full".
  localparam logic [FETCH_CNT_W-1:0] FETCH_FULL_CNT = FETCH_CNT_W'(FETCH_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

  // Clears the byte-offset bits so the PC always points at a whole word.
  function automatic logic [FETCH_ADDR_W-1:0] word_align(
    input logic [FETCH_ADDR_W-1:0] addr
  );
    return {addr[FETCH_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Two-entry synchronous FIFO of fetch_entry_t with a registered head.
// Slot 0 is always the head, so the head output comes straight from a flop.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   push       : write wdata this cycle (ignored when full without a pop)
//   pop        : remove the head this cycle (ignored when empty)
//   flush      : discard all entries; wins over push and pop
//   wdata      : entry to write
//   head       : current head entry (meaningful when count != 0)
//   count      : number of valid entries, 0..FETCH_DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic [FETCH_CNT_W-1:0] count
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic         do_pop;
  logic         do_push;

  always_comb begin
    do_pop  = pop && (count != '0);
    // A full FIFO can still accept a write when the head leaves this cycle.
    do_push = push && ((count < FETCH_FULL_CNT) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == '0) slot0 <= wdata;
          else             slot1 <= wdata;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (count == 2'd1) begin
            slot0 <= wdata;
          end else begin
            slot0 <= slot1;
            slot1 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Instruction fetch sequencer. Owns the PC, drives the combinational-read
// instruction memory address, and buffers fetched words in a 2-entry prefetch
// FIFO that feeds decode.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. An entry
// transfers on a rising edge where both are high; while out_valid is high and
// out_ready is low, out_pc/out_inst are held stable. out_valid never depends
// combinationally on out_ready.
//
// Optional feature: define FETCH_STATS_EN to add perf_fetch_cnt and
// perf_stall_cnt outputs.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start / stop    : single-cycle pulses (IDLE->RUN, RUN->DRAIN)
//   redirect_valid  : flush the FIFO and load redirect_pc (word aligned)
//   imem_ra/imem_rd : instruction memory read address (=PC) / data
//   out_valid/out_ready/out_pc/out_inst : decode-side FIFO head
//   busy            : state != IDLE
//   dbg_state       : current FSM state
//   dbg_count       : FIFO occupancy
//   perf_fetch_cnt  : pushes since reset (FETCH_STATS_EN only)
//   perf_stall_cnt  : RUN cycles with a full FIFO and no pop (FETCH_STATS_EN)
// -----------------------------------------------------------------------------
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                     INS_ADDRESS = FETCH_ADDR_W,
  parameter int                     INS_W       = FETCH_INST_W,
  parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INS_ADDRESS-1:0] out_pc,
  output logic [INS_W-1:0]       out_inst,
  output logic                   busy,
  output fetch_state_t           dbg_state,
  output logic [FETCH_CNT_W-1:0] dbg_count
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_stall_cnt
`endif
);

  fetch_state_t             state;
  fetch_state_t             state_next;
  logic [INS_ADDRESS-1:0]   pc;
  logic [INS_ADDRESS-1:0]   pc_next;
  logic                     pop;
  logic                     push;
  fetch_entry_t             fifo_wdata;
  fetch_entry_t             fifo_head;
  logic [FETCH_CNT_W-1:0]   count;

  // ---------------------------------------------------------------------------
  // Handshake and push decision
  // ---------------------------------------------------------------------------
  always_comb begin
    pop  = out_valid && out_ready;
    // A redirect cycle never pushes: the word at the old PC is stale.
    push = (state == RUN) && !redirect_valid &&
           ((count < FETCH_FULL_CNT) || pop);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;     // start beats a same-cycle stop
      RUN:     if (stop)  state_next = DRAIN;
      DRAIN:   if (count == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Program counter (wraps modulo 2^INS_ADDRESS)
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_next = pc;
    if (redirect_valid) pc_next = word_align(redirect_pc);
    else if (push)      pc_next = pc + INS_ADDRESS'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_wdata      = '0;
    fifo_wdata.pc   = pc;
    fifo_wdata.inst = imem_rd;
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (fifo_wdata),
    .head  (fifo_head),
    .count (count)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_ra   = pc;
  assign out_valid = (count != '0);
  assign out_pc    = fifo_head.pc;
  assign out_inst  = fifo_head.inst;
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign dbg_count = count;

`ifdef FETCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic stall;

  assign stall = (state == RUN) && (count == FETCH_FULL_CNT) && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
// Self-checking bench for fetch_controller. A behavioural instruction memory
// answers imem_ra combinationally. Whenever the bench starts or redirects the
// fetch stream it pushes the expected {pc, inst} sequence into exp_q; a
// monitor pops and compares on every completed out_valid/out_ready handshake.
// Directed checks cover reset, latency, back-pressure, redirect, wrap, drain
// and mid-run reset.
// -----------------------------------------------------------------------------
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int AW = 9;
  localparam int IW = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               start;
  logic               stop;
  logic               redirect_valid;
  logic [AW-1:0]      redirect_pc;
  logic [AW-1:0]      imem_ra;
  logic [IW-1:0]      imem_rd;
  logic               out_valid;
  logic               out_ready;
  logic [AW-1:0]      out_pc;
  logic [IW-1:0]      out_inst;
  logic               busy;
  fetch_state_t       dbg_state;
  logic [1:0]         dbg_count;
`ifdef FETCH_STATS_EN
  logic [31:0]        perf_fetch_cnt;
  logic [31:0]        perf_stall_cnt;
`endif

  fetch_controller dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_ra        (imem_ra),
    .imem_rd        (imem_rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .busy           (busy),
    .dbg_state      (dbg_state),
    .dbg_count      (dbg_count)
`ifdef FETCH_STATS_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Instruction memory: 128 words, combinational read.
  logic [IW-1:0] mem [128];
  assign imem_rd = mem[imem_ra[AW-1:2]];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [AW+IW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_expect(input logic [AW-1:0] first_pc, input int n);
    logic [AW-1:0] p;
    p = first_pc;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({p, mem[p[AW-1:2]]});
      p = p + AW'(4);
    end
  endtask

  // Every completed handshake must match the next expected entry.
  always @(negedge clk) begin
    logic [AW+IW-1:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("pop_with_empty_queue", 64'(0), 64'(1));
      end else begin
        e = exp_q.pop_front();
        check_eq("pop_pc", 64'(out_pc), 64'(e[AW+IW-1:IW]));
        check_eq("pop_inst", 64'(out_inst), 64'(e[IW-1:0]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    exp_q.delete();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_imem_ra", 64'(imem_ra), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_out_pc", 64'(out_pc), 64'(0));
    check_eq("rst_out_inst", 64'(out_inst), 64'(0));
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
    check_eq("rst_count", 64'(dbg_count), 64'(0));
`ifdef FETCH_STATS_EN
    check_eq("rst_perf_fetch", 64'(perf_fetch_cnt), 64'(0));
    check_eq("rst_perf_stall", 64'(perf_stall_cnt), 64'(0));
`endif
    next_cycle();
    reset = 1'b0;
  endtask

  // Watchdog: the test is a few hundred cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom_range(32'hFFFF_FFFF, 0);
    mem[0] = 32'h0000_7033;
    mem[1] = 32'h0010_0093;

    // Start with out_ready held high: latency and throughput.
    do_reset();
    out_ready = 1'b1;
    start     = 1'b1;
    push_expect(9'h000, 64);
    @(negedge clk);
    check_eq("start_c0_valid", 64'(out_valid), 64'(0));
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check_eq("start_c1_valid", 64'(out_valid), 64'(0));
    check_eq("start_c1_busy", 64'(busy), 64'(1));
    check_eq("start_c1_state", 64'(dbg_state), 64'(RUN));
    next_cycle();
    @(negedge clk);
    check_eq("start_c2_valid", 64'(out_valid), 64'(1));
    check_eq("first_pc", 64'(out_pc), 64'(9'h000));
    check_eq("first_inst", 64'(out_inst), 64'(32'h0000_7033));
    next_cycle();
    @(negedge clk);
    check_eq("second_pc", 64'(out_pc), 64'(9'h004));
    check_eq("second_inst", 64'(out_inst), 64'(32'h0010_0093));
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check_eq("throughput_valid", 64'(out_valid), 64'(1));
    end

    // Fill the FIFO, then redirect to an unaligned PC.
    next_cycle();
    out_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    check_eq("fill_count", 64'(dbg_count), 64'(2));
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 9'h023;
    exp_q.delete();
    push_expect(9'h020, 40);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("redir_valid_low", 64'(out_valid), 64'(0));
    check_eq("redir_imem_ra", 64'(imem_ra), 64'(9'h020));
    check_eq("redir_count", 64'(dbg_count), 64'(0));
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("redir_out_valid", 64'(out_valid), 64'(1));
    check_eq("redir_out_pc", 64'(out_pc), 64'(9'h020));

    // Address wrap: redirect to the last word.
    next_cycle();
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 9'h1FC;
    exp_q.delete();
    push_expect(9'h1FC, 8);
    next_cycle();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    @(negedge clk);
    check_eq("wrap_imem_ra", 64'(imem_ra), 64'(9'h1FC));
    next_cycle();
    @(negedge clk);
    check_eq("wrap_pc_last", 64'(out_pc), 64'(9'h1FC));
    next_cycle();
    @(negedge clk);
    check_eq("wrap_pc_zero", 64'(out_pc), 64'(9'h000));
    check_eq("wrap_inst_zero", 64'(out_inst), 64'(32'h0000_7033));
    next_cycle();

    // Back-pressure from a fresh start: FIFO saturates, PC freezes.
    do_reset();
    out_ready = 1'b0;
    start     = 1'b1;
    push_expect(9'h000, 32);
    next_cycle();
    start = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    check_eq("bp_count", 64'(dbg_count), 64'(2));
    check_eq("bp_imem_ra", 64'(imem_ra), 64'(9'h008));
    check_eq("bp_out_valid", 64'(out_valid), 64'(1));
    check_eq("bp_out_pc", 64'(out_pc), 64'(9'h000));
    next_cycle();
    @(negedge clk);
    check_eq("bp_imem_ra_hold", 64'(imem_ra), 64'(9'h008));
    check_eq("bp_out_inst_hold", 64'(out_inst), 64'(32'h0000_7033));
`ifdef FETCH_STATS_EN
    check_eq("bp_perf_fetch", 64'(perf_fetch_cnt), 64'(2));
`endif
    next_cycle();
    out_ready = 1'b1;
    repeat (5) next_cycle();

    // Stop with two entries queued; start during DRAIN is ignored.
    do_reset();
    out_ready = 1'b0;
    start     = 1'b1;
    push_expect(9'h000, 16);
    next_cycle();
    start = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check_eq("stop_pre_count", 64'(dbg_count), 64'(2));
    next_cycle();
    stop = 1'b1;
    next_cycle();
    stop      = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("drain_state", 64'(dbg_state), 64'(DRAIN));
    check_eq("drain_busy", 64'(busy), 64'(1));
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
      next_cycle();
    end
    check_eq("drain_idle_busy", 64'(busy), 64'(0));
    check_eq("drain_idle_state", 64'(dbg_state), 64'(IDLE));
    check_eq("drain_idle_valid", 64'(out_valid), 64'(0));
    repeat (3) next_cycle();
    @(negedge clk);
    check_eq("idle_no_push", 64'(out_valid), 64'(0));
    check_eq("idle_saved_pc", 64'(imem_ra), 64'(9'h008));
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    @(negedge clk);
    check_eq("resume_valid", 64'(out_valid), 64'(1));
    check_eq("resume_pc", 64'(out_pc), 64'(9'h008));

    // Reset in the middle of RUN with a full FIFO.
    next_cycle();
    out_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    check_eq("midrst_pre_count", 64'(dbg_count), 64'(2));
    next_cycle();
    reset = 1'b1;
    exp_q.delete();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", 64'(out_valid), 64'(0));
    check_eq("midrst_imem_ra", 64'(imem_ra), 64'(0));
    check_eq("midrst_busy", 64'(busy), 64'(0));
    check_eq("midrst_count", 64'(dbg_count), 64'(0));
`ifdef FETCH_STATS_EN
    check_eq("midrst_perf_fetch", 64'(perf_fetch_cnt), 64'(0));
`endif
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction fetch sequencer for the RISC-V core. Owns the program counter, drives the read address of the combinational-read instruction memory, and buffers fetched words in a 2-entry prefetch FIFO. The FIFO feeds decode over a valid/ready handshake. Sits between the instruction memory and the decode stage, and accepts start/stop control plus branch/jump redirects from execute.

## Interface
- INS_ADDRESS, 9, byte-address width of the instruction memory read port.
- INS_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset (INS_ADDRESS bits, word aligned).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; IDLE -> RUN.
- stop  in  1  single-cycle pulse; RUN -> DRAIN.
- redirect_valid  in  1  flush the FIFO and load the PC.
- redirect_pc  in  INS_ADDRESS  new PC; bits [1:0] are ignored and forced to 0.
- imem_ra  out  INS_ADDRESS  instruction memory read address; equals the PC.
- imem_rd  in  INS_W  instruction memory read data, valid in the same cycle as imem_ra.
- out_valid  out  1  FIFO head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  INS_ADDRESS  PC of the head entry.
- out_inst  out  INS_W  instruction of the head entry.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset state is IDLE.
- IDLE: no push. start -> RUN.
- RUN: no state change on start. stop -> DRAIN.
- DRAIN: no push. FIFO empty -> IDLE. start is ignored.
- Push condition: state==RUN, no redirect_valid, and (count<2 or pop this cycle). A push writes {pc, imem_rd} and sets pc <= pc+4.
- Pop: out_valid && out_ready.
- PC arithmetic is modulo 2^INS_ADDRESS; the last word wraps to address 0 silently.
- redirect_valid, in any state:
  - FIFO cleared; count=0 next cycle.
  - pc <= {redirect_pc[INS_ADDRESS-1:2], 2'b00}.
  - No push that cycle.
  - A pop in the same cycle is still a completed handshake.
- redirect_valid with stop in the same cycle: the PC loads and the state goes to DRAIN. The FIFO is empty, so the next cycle goes to IDLE.
- start and stop in the same cycle in IDLE: start wins.
- out_pc/out_inst are don't-care when out_valid=0; they are held at 0 after reset.
- Reset values:
  - pc=RESET_PC, imem_ra=RESET_PC.
  - count=0, out_valid=0, out_pc=0, out_inst=0.
  - busy=0, state=IDLE.
- Reset mid-operation discards all FIFO contents and any pending redirect.

## Timing
- imem_ra is combinational from the PC register.
- Fetch-to-decode latency: 1 cycle. A word pushed at edge t is visible at out_* after edge t.
- Throughput: 1 instruction/cycle with out_ready held at 1.
- Redirect at cycle t:
  - imem_ra = new PC in cycle t+1.
  - First new out_valid in cycle t+2.
- start at cycle t: first push at edge t+1, out_valid high in cycle t+2.
- Back-pressure: with out_ready=0 and count=2, the PC holds and imem_ra is stable.
- out_valid stays high and out_pc/out_inst stay constant until popped or flushed.

## Configuration
- The macro `FETCH_STATS_EN` controls optional performance counters.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (increments per push) and perf_stall_cnt[31:0] (increments per cycle with state==RUN, count==2 and no pop).
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Package fetch_pkg holds:
  - the fetch_state_t enum {IDLE, RUN, DRAIN};
  - the fetch_entry_t struct {pc, inst};
  - the constant FETCH_DEPTH=2.
- Sub-module fetch_fifo is a 2-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count and a registered head. Flush has priority over push.
- The FSM, PC register and counters live in the top level.

## Test plan
- Reset, then start, with memory word0=0x00007033 and word1=0x00100093, and out_ready=1:
  - out_valid rises 2 cycles after start;
  - out_pc=0x000 with out_inst=0x00007033, then 0x004 with 0x00100093.
- Hold out_ready=0 for 5 cycles in RUN:
  - count saturates at 2 and imem_ra freezes at 0x008;
  - after release, out_pc continues 0x000, 0x004, 0x008 with no gaps or duplicates.
- redirect_valid with redirect_pc=0x023 while the FIFO is full:
  - out_valid=0 the next cycle, imem_ra=0x020;
  - the next out_pc=0x020.
- PC at 0x1FC in RUN: the pushes give out_pc 0x1FC then 0x000.
- stop with 2 entries queued:
  - both entries drain, then state is IDLE and busy=0;
  - no further pushes; a later start resumes from the saved PC.
- reset asserted mid-RUN with a full FIFO: the next cycle has out_valid=0, imem_ra=RESET_PC and busy=0. With `FETCH_STATS_EN` defined, perf_fetch_cnt is also 0.
